// File: rtl/clk_div_ctrl.sv
// Run-time programmable clock divider: glitch-free start/stop, one-cycle tick per
// output edge, optional burst length, and shadowed reconfiguration while running.
module clk_div_ctrl #(
  parameter int unsigned      CNT_W       = 32,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(2499999),
  parameter int unsigned      BURST_W     = 16
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               en,
  input  logic               cfg_valid,
  input  logic [CNT_W-1:0]   cfg_div,
  input  logic [BURST_W-1:0] cfg_burst,
  output logic               cfg_ready,
  output logic               divided_clk,
  output logic               tick,
  output logic               busy,
  output logic               done,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    PEND     = 2'd2,
    STOPPING = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt, div_reg, shd_div;
  logic [BURST_W-1:0] burst_reg, shd_burst, per_cnt;
  logic               shd_vld, hold;

  logic               cfg_acc, wrap, burst_end, do_load;
  logic [CNT_W-1:0]   cnt_nxt, next_div;
  logic [BURST_W-1:0] per_nxt, next_burst;

  // Config handshake: a transfer happens on any posedge where cfg_valid && cfg_ready;
  // the offerer holds cfg_div/cfg_burst stable until then. Ready only in IDLE and RUN.
  assign cfg_ready = (state == IDLE) || (state == RUN);
  assign cfg_acc   = cfg_valid && cfg_ready;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  assign cnt_nxt   = cnt + CNT_W'(1);
  assign per_nxt   = per_cnt + BURST_W'(1);
  assign wrap      = (cnt == div_reg);
  assign burst_end = wrap && divided_clk && (burst_reg != '0) && (per_nxt == burst_reg);

  // On a return to IDLE a waiting shadow wins; otherwise a same-edge accept loads directly.
  assign do_load    = shd_vld || cfg_acc;
  assign next_div   = shd_vld ? shd_div : cfg_div;
  assign next_burst = shd_vld ? shd_burst : cfg_burst;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      div_reg     <= DEFAULT_DIV;
      burst_reg   <= '0;
      per_cnt     <= '0;
      shd_div     <= '0;
      shd_burst   <= '0;
      shd_vld     <= 1'b0;
      hold        <= 1'b0;
      divided_clk <= 1'b0;
      tick        <= 1'b0;
      done        <= 1'b0;
    end else begin
      tick <= 1'b0;
      done <= 1'b0;
      if (!en) hold <= 1'b0;
      if (state == IDLE) begin
        divided_clk <= 1'b0;
        cnt         <= '0;
        if (cfg_acc) begin
          div_reg   <= cfg_div;
          burst_reg <= cfg_burst;
        end
        // hold keeps a finished burst from restarting until en is dropped
        if (en && !hold) begin
          state   <= RUN;
          per_cnt <= '0;
        end
      end else if (!en && !divided_clk) begin
        state   <= IDLE;
        cnt     <= '0;
        shd_vld <= 1'b0;
        if (do_load) begin
          div_reg   <= next_div;
          burst_reg <= next_burst;
        end
      end else if (wrap) begin
        cnt         <= '0;
        divided_clk <= ~divided_clk;
        tick        <= 1'b1;
        if (divided_clk && (burst_end || !en || state == STOPPING)) begin
          state   <= IDLE;
          per_cnt <= '0;
          done    <= burst_end;
          shd_vld <= 1'b0;
          if (burst_end) hold <= en;
          if (do_load) begin
            div_reg   <= next_div;
            burst_reg <= next_burst;
          end
        end else if (shd_vld) begin
          div_reg   <= shd_div;
          burst_reg <= shd_burst;
          per_cnt   <= '0;
          shd_vld   <= 1'b0;
          state     <= RUN;
        end else begin
          if (divided_clk) per_cnt <= per_nxt;
          if (cfg_acc) begin
            shd_div   <= cfg_div;
            shd_burst <= cfg_burst;
            shd_vld   <= 1'b1;
            state     <= PEND;
          end
        end
      end else begin
        cnt <= cnt_nxt;
        if (cfg_acc) begin
          shd_div   <= cfg_div;
          shd_burst <= cfg_burst;
          shd_vld   <= 1'b1;
        end
        // en low here means the high phase is in progress: finish it out
        if (!en) state <= STOPPING;
        else if (cfg_acc) state <= PEND;
      end
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: directed scenarios plus random traffic, all checked
// cycle by cycle against a countdown/period-count reference model.
module tb_clk_div_ctrl;

  localparam logic [31:0] DEF_DIV = 32'd3;
  localparam int M_IDLE = 0, M_RUN = 1, M_STOP = 2;

  logic        clk_in = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [31:0] cfg_div = '0;
  logic [15:0] cfg_burst = '0;
  logic        cfg_ready, divided_clk, tick, busy, done;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [4:0] exp_q[$];
  logic       trace_q[$];

  // reference model state
  int          m_mode, m_left, m_periods;
  logic        m_clk, m_tick, m_done, m_pend, m_hold;
  logic [31:0] m_div, m_pdiv;
  logic [15:0] m_burst, m_pburst;

  clk_div_ctrl #(.CNT_W(32), .DEFAULT_DIV(DEF_DIV), .BURST_W(16)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .en(en), .cfg_valid(cfg_valid),
    .cfg_div(cfg_div), .cfg_burst(cfg_burst), .cfg_ready(cfg_ready),
    .divided_clk(divided_clk), .tick(tick), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk_in = ~clk_in;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_left = 0; m_periods = 0;
    m_clk = 0; m_tick = 0; m_done = 0; m_pend = 0; m_hold = 0;
    m_div = DEF_DIV; m_burst = '0; m_pdiv = '0; m_pburst = '0;
    exp_q.delete();
  endtask

  task automatic settle_cfg(input bit acc, input logic [31:0] cd, input logic [15:0] cb);
    if (m_pend) begin
      m_div = m_pdiv; m_burst = m_pburst;
    end else if (acc) begin
      m_div = cd; m_burst = cb;
    end
    m_pend = 0;
  endtask

  // One posedge of the reference: m_left counts edges remaining to the next toggle.
  task automatic model_edge(input logic e, input logic cv, input logic [31:0] cd, input logic [15:0] cb);
    bit ready, acc, fin;
    ready = (m_mode == M_IDLE) || (m_mode == M_RUN && !m_pend);
    acc = cv && ready;
    m_tick = 0;
    m_done = 0;
    if (!e) m_hold = 0;
    if (m_mode == M_IDLE) begin
      if (acc) begin m_div = cd; m_burst = cb; end
      if (e && !m_hold) begin
        m_mode = M_RUN; m_left = int'(m_div) + 1; m_periods = 0;
      end
    end else if (!e && !m_clk) begin
      m_mode = M_IDLE;
      settle_cfg(acc, cd, cb);
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_clk = !m_clk;
        m_tick = 1;
        if (!m_clk) begin
          m_periods++;
          fin = (m_burst != 0) && (m_periods == int'(m_burst));
          if (fin || m_mode == M_STOP || !e) begin
            m_mode = M_IDLE;
            m_done = fin;
            if (fin) m_hold = e;
            settle_cfg(acc, cd, cb);
          end
        end
        if (m_mode != M_IDLE) begin
          if (m_pend) begin
            m_div = m_pdiv; m_burst = m_pburst; m_pend = 0; m_periods = 0;
          end else if (acc) begin
            m_pdiv = cd; m_pburst = cb; m_pend = 1;
          end
          m_left = int'(m_div) + 1;
        end
      end else begin
        if (m_mode == M_RUN && !e) m_mode = M_STOP;
        if (acc) begin m_pdiv = cd; m_pburst = cb; m_pend = 1; end
      end
    end
    exp_q.push_back({m_clk, m_tick, m_done, m_mode != M_IDLE,
                     (m_mode == M_IDLE) || (m_mode == M_RUN && !m_pend)});
  endtask

  // driver: apply inputs, clock one edge, compare all outputs 1 time unit later
  task automatic step(input logic e, input logic cv, input logic [31:0] cd, input logic [15:0] cb);
    logic [4:0] exp_v;
    en = e; cfg_valid = cv; cfg_div = cd; cfg_burst = cb;
    @(posedge clk_in);
    model_edge(e, cv, cd, cb);
    #1;
    exp_v = exp_q.pop_front();
    check_eq("divided_clk", divided_clk, exp_v[4]);
    check_eq("tick", tick, exp_v[3]);
    check_eq("done", done, exp_v[2]);
    check_eq("busy", busy, exp_v[1]);
    check_eq("cfg_ready", cfg_ready, exp_v[0]);
  endtask

  task automatic run_to_rise(output int idx);
    idx = -1;
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b0, '0, '0);
      if (divided_clk) begin idx = i; break; end
    end
  endtask

  task automatic stop_all();
    for (int i = 0; i < 14; i++) step(1'b0, 1'b0, '0, '0);
    check_eq("stop_busy", busy, 0);
  endtask

  task automatic measure(output int r0, output int r1);
    int k;
    r0 = 0; r1 = 0; k = 0;
    while (k < trace_q.size() && trace_q[k] == trace_q[0]) begin r0++; k++; end
    while (k < trace_q.size() && trace_q[k] != trace_q[0]) begin r1++; k++; end
  endtask

  task automatic async_reset(input string tag);
    #3;
    rst_n = 1'b0;
    cfg_valid = 1'b0;
    #1;
    check_eq({tag, "_clk"}, divided_clk, 0);
    check_eq({tag, "_tick"}, tick, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_ready"}, cfg_ready, 1);
    model_reset();
    @(posedge clk_in);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int idx, r0, r1, ndone;
    logic e;
    model_reset();
    repeat (3) @(posedge clk_in);
    #1;
    rst_n = 1'b1;
    check_eq("rst_clk", divided_clk, 0);
    check_eq("rst_tick", tick, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", cfg_ready, 1);

    // default divide: rise 4 cycles after en is sampled
    run_to_rise(idx);
    check_eq("t1_rise", idx, 5);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, '0, '0);
    stop_all();

    // burst of 3 at div 0, en held afterwards
    step(1'b0, 1'b1, 32'd0, 16'd3);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, '0, '0);
      ndone += int'(done);
    end
    check_eq("t2_done_count", ndone, 1);
    check_eq("t2_idle_clk", divided_clk, 0);
    check_eq("t2_idle_busy", busy, 0);
    stop_all();

    // reconfigure during the high phase
    step(1'b0, 1'b1, 32'd3, 16'd0);
    run_to_rise(idx);
    check_eq("t3_rise", idx, 5);
    trace_q.delete();
    trace_q.push_back(divided_clk);
    step(1'b1, 1'b1, 32'd1, 16'd0);
    trace_q.push_back(divided_clk);
    check_eq("t3_ready_low", cfg_ready, 0);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, '0, '0);
      trace_q.push_back(divided_clk);
    end
    measure(r0, r1);
    check_eq("t3_high_len", r0, 4);
    check_eq("t3_low_len", r1, 2);
    check_eq("t3_ready_back", cfg_ready, 1);
    stop_all();

    // drop en one cycle after a rising edge
    step(1'b0, 1'b1, 32'd5, 16'd0);
    run_to_rise(idx);
    check_eq("t4_rise", idx, 7);
    trace_q.delete();
    trace_q.push_back(divided_clk);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, '0, '0);
      trace_q.push_back(divided_clk);
    end
    measure(r0, r1);
    check_eq("t4_high_len", r0, 6);
    check_eq("t4_low_rest", r1, 7);
    check_eq("t4_busy", busy, 0);

    // asynchronous reset while high in a burst
    step(1'b0, 1'b1, 32'd2, 16'd5);
    run_to_rise(idx);
    check_eq("t5_rise", idx, 4);
    step(1'b1, 1'b0, '0, '0);
    async_reset("t5_rst");
    run_to_rise(idx);
    check_eq("t5_default_rise", idx, 5);
    stop_all();

    // config accepted on a toggle edge
    step(1'b0, 1'b1, 32'd3, 16'd0);
    run_to_rise(idx);
    check_eq("t6_rise", idx, 5);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, '0);
    step(1'b1, 1'b1, 32'd2, 16'd0);
    trace_q.delete();
    trace_q.push_back(divided_clk);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, '0, '0);
      trace_q.push_back(divided_clk);
    end
    measure(r0, r1);
    check_eq("t6_low_len", r0, 4);
    check_eq("t6_high_len", r1, 3);
    stop_all();

    // random traffic
    e = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) async_reset("rnd_rst");
      if ($urandom_range(0, 19) == 0) e = ~e;
      step(e, ($urandom_range(0, 5) == 0), 32'($urandom_range(0, 4)), 16'($urandom_range(0, 4)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
